instr_byte_packer: RTL and testbench

Byte-to-word packing stage that sits directly upstream of the instruction-word consumer. It accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit instruction words. Completed or flushed words are presented on a registered valid/ready output, together with a byte count. Its state register uses the team's sparse FSM encoding (IDLE=2, COUNT=7, LAST=11, 5-bit), so downstream debug logic can decode it directly.

---
 rtl/instr_byte_packer_if.sv | 25 ++
 rtl/instr_byte_packer.sv | 147 ++++++++++++++
 tb/tb_instr_byte_packer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_byte_packer_if.sv
// Byte-in / word-out handshake bundle for instr_byte_packer.
//   in_valid/in_byte/in_ready : upstream byte stream (valid/ready)
//   flush                     : close the current partial word
//   out_valid/out_word/out_count/out_ready : downstream word handoff
// master = producer/consumer side (testbench or neighbours), slave = packer.
interface instr_byte_packer_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_word;
  logic [2:0]  out_count;
  logic        out_ready;

  modport master (
    output in_valid, in_byte, flush, out_ready,
    input  in_ready, out_valid, out_word, out_count
  );

  modport slave (
    input  in_valid, in_byte, flush, out_ready,
    output in_ready, out_valid, out_word, out_count
  );
endinterface

// File: rtl/instr_byte_packer.sv
// instr_byte_packer: packs an 8-bit byte stream into 32-bit instruction words.
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   bus (slave)     : byte input handshake, flush, word output handshake
//   state_o [4:0]   : FSM state code (IDLE=2, COUNT=7, LAST=11)
//   word_cnt        : words handed off since reset, wraps
// Build option: define INSTR_ASM_BIG_ENDIAN_EN to place the first byte in
// out_word[31:24] instead of out_word[7:0].
module instr_byte_packer #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_byte_packer_if.slave   bus,
  output logic [4:0]           state_o,
  output logic [CNT_W-1:0]     word_cnt
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'd2,
    S_COUNT = 5'd7,
    S_LAST  = 5'd11
  } state_t;

  localparam logic [31:0] PAD_WORD = {4{PAD_BYTE}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [31:0]      r_word;
  logic [31:0]      w_word_nxt;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_handoff;

  // Write byte b into lane k of word w (lane order depends on build).
  function automatic logic [31:0] put_lane(input logic [31:0] w,
                                           input logic [1:0]  k,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
`ifdef INSTR_ASM_BIG_ENDIAN_EN
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
`else
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
`endif
    return r;
  endfunction

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_handoff = r_out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, fill count and word assembly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_word_nxt  = put_lane(PAD_WORD, 2'd0, bus.in_byte);
          w_cnt_nxt   = 3'd1;
          w_state_nxt = bus.flush ? S_LAST : S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_accept) begin
          w_word_nxt  = put_lane(r_word, r_cnt[1:0], bus.in_byte);
          w_cnt_nxt   = 3'(r_cnt + 3'd1);
          w_state_nxt = (r_cnt == 3'd3 || bus.flush) ? S_LAST : S_COUNT;
        end else if (bus.flush) begin
          w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        // Flush without handoff is ignored; the held word stays stable.
        if (w_handoff) begin
          if (w_accept) begin
            w_word_nxt  = put_lane(PAD_WORD, 2'd0, bus.in_byte);
            w_cnt_nxt   = 3'd1;
            w_state_nxt = bus.flush ? S_LAST : S_COUNT;
          end else begin
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_cnt_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte-side ready: free in IDLE/COUNT, follows out_ready while a word waits.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_COUNT: w_in_ready = 1'b1;
      S_LAST:          w_in_ready = bus.out_ready;
      default:         w_in_ready = 1'b0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 3'd0;
      r_word      <= 32'd0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_out_valid <= (w_state_nxt == S_LAST);
      if (w_handoff) r_word_cnt <= CNT_W'(r_word_cnt + 1'b1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_word;
  assign bus.out_count = r_cnt;
  assign state_o       = r_state;
  assign word_cnt      = r_word_cnt;

endmodule

// File: tb/tb_instr_byte_packer.sv
// Directed self-checking bench for instr_byte_packer (CNT_W=4 for wrap).
module tb_instr_byte_packer;
  localparam int unsigned CNT_W = 4;

`ifdef INSTR_ASM_BIG_ENDIAN_EN
  localparam logic [31:0] W_DEAD  = 32'hEFBEADDE;
  localparam logic [31:0] W_AA    = 32'hAA000000;
  localparam logic [31:0] W_123   = 32'h11223300;
  localparam logic [31:0] W_0104  = 32'h01020304;
  localparam logic [31:0] W_55    = 32'h55000000;
  localparam logic [31:0] W_5588  = 32'h55667788;
  localparam logic [31:0] W_C     = 32'hC1C2C3C4;
  localparam logic [31:0] W_T1    = 32'h10203040;
  localparam logic [31:0] W_T2    = 32'h50607080;
`else
  localparam logic [31:0] W_DEAD  = 32'hDEADBEEF;
  localparam logic [31:0] W_AA    = 32'h000000AA;
  localparam logic [31:0] W_123   = 32'h00332211;
  localparam logic [31:0] W_0104  = 32'h04030201;
  localparam logic [31:0] W_55    = 32'h00000055;
  localparam logic [31:0] W_5588  = 32'h88776655;
  localparam logic [31:0] W_C     = 32'hC4C3C2C1;
  localparam logic [31:0] W_T1    = 32'h40302010;
  localparam logic [31:0] W_T2    = 32'h80706050;
`endif

  logic             clk;
  logic             reset;
  logic [4:0]       state_o;
  logic [CNT_W-1:0] word_cnt;
  int               n_cmp;
  int               n_err;
  logic [31:0]      held;

  instr_byte_packer_if bus ();

  instr_byte_packer #(.CNT_W(CNT_W), .PAD_BYTE(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_o  (state_o),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.flush    = fl;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_state", 64'(state_o), 64'd2);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_word", 64'(bus.out_word), 64'd0);
    chk("rst_out_count", 64'(bus.out_count), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Full word EF BE AD DE, back to back
    send(8'hEF, 1'b0);
    chk("w1_state_count", 64'(state_o), 64'd7);
    send(8'hBE, 1'b0);
    send(8'hAD, 1'b0);
    chk("w1_not_valid_yet", 64'(bus.out_valid), 64'd0);
    send(8'hDE, 1'b0);
    chk("w1_valid", 64'(bus.out_valid), 64'd1);
    chk("w1_word", 64'(bus.out_word), 64'(W_DEAD));
    chk("w1_count", 64'(bus.out_count), 64'd4);
    chk("w1_state_last", 64'(state_o), 64'd11);
    tick();
    chk("w1_valid_one_cycle", 64'(bus.out_valid), 64'd0);
    chk("w1_word_cnt", 64'(word_cnt), 64'd1);
    chk("w1_state_idle", 64'(state_o), 64'd2);

    // Flush alone in IDLE is ignored
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("idle_flush_ignored", 64'(state_o), 64'd2);

    // Byte AA then flush alone
    send(8'hAA, 1'b0);
    chk("aa_state7", 64'(state_o), 64'd7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("aa_state11", 64'(state_o), 64'd11);
    chk("aa_word", 64'(bus.out_word), 64'(W_AA));
    chk("aa_count", 64'(bus.out_count), 64'd1);
    tick();
    chk("aa_state2", 64'(state_o), 64'd2);
    chk("aa_word_cnt", 64'(word_cnt), 64'd2);

    // 11, 22, then 33 with flush
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    chk("f3_valid", 64'(bus.out_valid), 64'd1);
    chk("f3_word", 64'(bus.out_word), 64'(W_123));
    chk("f3_count", 64'(bus.out_count), 64'd3);
    tick();
    chk("f3_word_cnt", 64'(word_cnt), 64'd3);

    // Backpressure: full word held 5 cycles with a byte offered
    bus.out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("bp_word", 64'(bus.out_word), 64'(W_0104));
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h55;
    bus.flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("bp_word_stable", 64'(bus.out_word), 64'(W_0104));
      chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
      tick();
    end
    bus.flush = 1'b0;
    chk("bp_count_stable", 64'(bus.out_count), 64'd4);
    chk("bp_word_cnt_held", 64'(word_cnt), 64'd3);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_state7", 64'(state_o), 64'd7);
    chk("bp_word_cnt", 64'(word_cnt), 64'd4);
    chk("bp_new_count", 64'(bus.out_count), 64'd1);
    chk("bp_new_valid", 64'(bus.out_valid), 64'd0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    chk("bp_next_word", 64'(bus.out_word), 64'(W_5588));
    tick();
    chk("bp_next_word_cnt", 64'(word_cnt), 64'd5);

    // Reset mid-word
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", 64'(state_o), 64'd2);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    chk("clean_word", 64'(bus.out_word), 64'(W_C));
    chk("clean_count", 64'(bus.out_count), 64'd4);

    // Reset coincident with a handoff wins; counter not bumped
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_handoff_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_handoff_valid", 64'(bus.out_valid), 64'd0);

    // Sustained throughput: 8 bytes on 8 consecutive cycles
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    chk("tp_word1", 64'(bus.out_word), 64'(W_T1));
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h50;
    #1;
    chk("tp_overlap_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("tp_overlap_state", 64'(state_o), 64'd7);
    chk("tp_overlap_word_cnt", 64'(word_cnt), 64'd1);
    send(8'h60, 1'b0);
    send(8'h70, 1'b0);
    send(8'h80, 1'b0);
    chk("tp_word2", 64'(bus.out_word), 64'(W_T2));
    held = bus.out_word;
    tick();
    chk("tp_word_cnt", 64'(word_cnt), 64'd2);

    // Counter wrap with CNT_W=4: 13 more handoffs reach 15, one more wraps
    for (int i = 0; i < 13; i++) begin
      send(8'(i), 1'b1);
      tick();
    end
    chk("wrap_all_ones", 64'(word_cnt), 64'hF);
    send(8'hEE, 1'b1);
    chk("wrap_1byte_count", 64'(bus.out_count), 64'd1);
    tick();
    chk("wrap_zero", 64'(word_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
